// File: rtl/fp_operand_unpack.sv
// fp_operand_unpack: unpacks and classifies an FP operand pair behind a skid-buffered valid/ready stage
module fp_operand_unpack #(
  parameter bit FTZ = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign_A,
  output logic        sign_B,
  output logic [7:0]  exp_A,
  output logic [7:0]  exp_B,
  output logic [22:0] mantis_A,
  output logic [22:0] mantis_B,
  output logic [2:0]  type_A,
  output logic [2:0]  type_B
);
  typedef enum logic [2:0] {
    T_ZERO = 3'b000,
    T_INF  = 3'b001,
    T_SUB  = 3'b010,
    T_NORM = 3'b011,
    T_NAN  = 3'b100
  } fp_type_e;
  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [2:0]  t;
  } op_t;
  typedef struct packed {
    op_t a;
    op_t b;
  } pair_t;
  function automatic op_t unpack(input logic [31:0] x, input logic flip);
    op_t  o;
    logic e_zero, e_max, m_zero;
    e_zero = x[30:23] == 8'h00;
    e_max  = x[30:23] == 8'hFF;
    m_zero = x[22:0] == 23'd0;
    o.s = x[31] ^ flip;
    o.e = x[30:23];
    o.m = (FTZ && e_zero) ? 23'd0 : x[22:0];
    o.t = e_max ? (m_zero ? T_INF : T_NAN) : !e_zero ? T_NORM : (m_zero || FTZ) ? T_ZERO : T_SUB;
    return o;
  endfunction
  pair_t in_pair, m_d, m_q, s_d, s_q;
  logic  out_valid_d, out_valid_q, s_valid_d, s_valid_q, accept, drain;
  assign in_ready = ~s_valid_q;
  // S only fills while M is stalled, so it is never loaded in the same cycle M drains it
  always_comb begin
    in_pair     = {unpack(in_a, 1'b0), unpack(in_b, in_sub)};
    accept      = in_valid & in_ready;
    drain       = ~out_valid_q | out_ready;
    m_d         = drain ? (s_valid_q ? s_q : accept ? in_pair : m_q) : m_q;
    s_d         = (!drain && accept) ? in_pair : s_q;
    out_valid_d = drain ? (s_valid_q | accept) : out_valid_q;
    s_valid_d   = drain ? 1'b0 : (s_valid_q | accept);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q         <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      s_valid_q   <= 1'b0;
    end else begin
      m_q         <= m_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      s_valid_q   <= s_valid_d;
    end
  end
  assign out_valid                            = out_valid_q;
  assign {sign_A, exp_A, mantis_A, type_A}    = m_q.a;
  assign {sign_B, exp_B, mantis_B, type_B}    = m_q.b;
endmodule
